dynamic_branch_predictor: RTL and testbench
===========================================

Name: dynamic_branch_predictor

Overview:
Fetch-stage predictor combining a 2-bit saturating-counter Branch History Table (BHT) with a tagged Branch Target Buffer (BTB). Each cycle it looks up the fetch PC and returns a taken prediction and predicted target. The fetch PC mux consumes both, and the target travels down the pipe as IF_ID_predicted_target. It is trained one cycle later-in-pipe by the decode-stage branch resolution outputs: wen_BHT, taken, wen_BTB and actual_target.

Parameters:
IDX_W, 3, index width; table depth = 2**IDX_W entries; index = PC[IDX_W:1].
TAG_W, 16-IDX_W-1, tag width; tag = PC[15:IDX_W+1].

Ports:
clk  input  1  system clock, all state updates on posedge.
rst  input  1  asynchronous active-high reset.
PC_curr  input  16  fetch-stage PC to look up.
IF_ID_PC_curr  input  16  PC of the branch being resolved in decode (update address).
wen_BHT  input  1  update BHT entry at IF_ID_PC_curr this cycle.
actual_taken  input  1  resolved direction (Branch & taken from decode).
wen_BTB  input  1  write actual_target into BTB entry at IF_ID_PC_curr.
actual_target  input  16  resolved branch target.
prediction  output  2  counter value read for PC_curr (0 on miss).
predicted_taken  output  1  predict-taken for PC_curr.
predicted_target  output  16  BTB target for PC_curr (0 on miss).
hit  output  1  valid entry with matching tag for PC_curr.

Behaviour:
- Storage per entry: valid (1b), tag (TAG_W), counter (2b), target (16b); all flops, no SRAM.
- Reset (async, rst=1): all valid=0, counters=2'b01 (weakly not-taken), tags=0, targets=16'h0000. Outputs then read hit=0, prediction=2'b00, predicted_taken=0, predicted_target=16'h0000.
- Lookup (combinational, zero latency): hit = valid[i] & (tag[i]==PC_curr tag). prediction = hit ? counter[i] : 2'b00. predicted_taken = hit & counter[i][1]. predicted_target = hit ? target[i] : 16'h0000.
- Update indexing: j = IF_ID_PC_curr[IDX_W:1]; u_hit = valid[j] & tag match.
- BHT update on posedge when wen_BHT=1:
  - u_hit=1: counter saturates. actual_taken=1 gives 00->01->10->11->11. actual_taken=0 gives 11->10->01->00->00.
  - u_hit=0 (allocate): valid[j]=1, tag[j]=IF_ID tag, counter[j]=actual_taken ? 2'b10 : 2'b01. target[j] is left unchanged unless wen_BTB is also asserted.
- BTB update on posedge when wen_BTB=1: target[j]=actual_target. If u_hit=0 and wen_BHT=0, the entry is also allocated (valid=1, tag set, counter=2'b10). wen_BTB implies the branch was taken.
- wen_BHT and wen_BTB together in one cycle: both applied to entry j atomically. Counter per BHT rule, target per BTB rule.
- Aliasing: different tag at same index replaces the entry (direct-mapped, no replacement policy).
- Update and lookup to same index in one cycle: lookup returns pre-update (registered) contents unless the bypass feature is enabled.
- Update inputs are accepted every cycle they are asserted. Decode guarantees one assertion per resolved branch, so stalls are handled upstream.
- rst asserted mid-operation clears state immediately regardless of clk. Updates pending in that cycle are discarded.
- PC[0] is ignored; instructions are 2-byte aligned.

Optional Feature:
BP_WRITE_BYPASS_EN
- Defined: when wen_BHT or wen_BTB targets the same index and tag as PC_curr in the same cycle, lookup outputs reflect the post-update entry combinationally (new counter/target/valid).
- Undefined: lookup always returns registered state, giving one-cycle-stale data on collision.

Test Plan:
1. Reset, then PC_curr=16'h0010 -> hit=0, prediction=2'b00, predicted_taken=0, predicted_target=16'h0000.
2. IF_ID_PC_curr=16'h0010, wen_BHT=1, wen_BTB=1, actual_taken=1, actual_target=16'h0040 for one cycle; then PC_curr=16'h0010 -> hit=1, prediction=2'b10, predicted_taken=1, predicted_target=16'h0040.
3. Continuing from 2, two not-taken updates (wen_BHT=1, actual_taken=0) -> prediction 01 then 00, predicted_taken=0, predicted_target still 16'h0040. A third not-taken update -> counter stays 00.
4. Continuing from 2, three taken updates -> counter saturates at 11 and never wraps to 00.
5. Alias: entry for 16'h0010 valid, then update IF_ID_PC_curr=16'h0020 (same index, IDX_W=3) taken with target 16'h0080 -> lookup 16'h0010 gives hit=0; lookup 16'h0020 gives hit=1, target 16'h0080.
6. Same-cycle update and lookup of 16'h0010 with new target 16'h0100 -> predicted_target=old value (macro off) or 16'h0100 (BP_WRITE_BYPASS_EN). Assert rst mid-sequence -> all outputs zero before the next clk edge.

Source files
------------

// File: rtl/dynamic_branch_predictor.sv
// Fetch-stage branch predictor: 2-bit saturating BHT plus tagged BTB, direct-mapped, trained from decode.
// Optional macro BP_WRITE_BYPASS_EN forwards a same-cycle update to the lookup outputs.
module dynamic_branch_predictor #(
  parameter int IDX_W = 3,
  parameter int TAG_W = 16 - IDX_W - 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] PC_curr,
  input  logic [15:0] IF_ID_PC_curr,
  input  logic        wen_BHT,
  input  logic        actual_taken,
  input  logic        wen_BTB,
  input  logic [15:0] actual_target,
  output logic [1:0]  prediction,
  output logic        predicted_taken,
  output logic [15:0] predicted_target,
  output logic        hit
);

  localparam int DEPTH = 1 << IDX_W;

  logic             valid_q [DEPTH];
  logic [TAG_W-1:0] tag_q   [DEPTH];
  logic [1:0]       cnt_q   [DEPTH];
  logic [15:0]      tgt_q   [DEPTH];

  logic             valid_d [DEPTH];
  logic [TAG_W-1:0] tag_d   [DEPTH];
  logic [1:0]       cnt_d   [DEPTH];
  logic [15:0]      tgt_d   [DEPTH];

  logic [IDX_W-1:0] lk_idx_s;
  logic [TAG_W-1:0] lk_tag_s;
  logic [IDX_W-1:0] up_idx_s;
  logic [TAG_W-1:0] up_tag_s;
  logic             u_hit_s;
  logic             up_en_s;
  logic             unused_s;

  logic             new_valid_s;
  logic [TAG_W-1:0] new_tag_s;
  logic [1:0]       new_cnt_s;
  logic [15:0]      new_tgt_s;

  logic             rd_valid_s;
  logic [TAG_W-1:0] rd_tag_s;
  logic [1:0]       rd_cnt_s;
  logic [15:0]      rd_tgt_s;
  logic             rd_hit_s;

  // PC[0] never participates: instructions are halfword aligned.
  assign unused_s = ^{PC_curr[0], IF_ID_PC_curr[0]};

  assign lk_idx_s = PC_curr[IDX_W:1];
  assign lk_tag_s = PC_curr[15:IDX_W+1];
  assign up_idx_s = IF_ID_PC_curr[IDX_W:1];
  assign up_tag_s = IF_ID_PC_curr[15:IDX_W+1];
  assign u_hit_s  = valid_q[up_idx_s] && (tag_q[up_idx_s] == up_tag_s);
  assign up_en_s  = wen_BHT || wen_BTB;

  // Post-update contents of the entry addressed by the decode-stage branch
  always_comb begin
    new_valid_s = valid_q[up_idx_s];
    new_tag_s   = tag_q[up_idx_s];
    new_cnt_s   = cnt_q[up_idx_s];
    new_tgt_s   = tgt_q[up_idx_s];
    if (wen_BHT) begin
      if (u_hit_s) begin
        if (actual_taken) begin
          new_cnt_s = (cnt_q[up_idx_s] == 2'b11) ? 2'b11 : cnt_q[up_idx_s] + 2'b01;
        end else begin
          new_cnt_s = (cnt_q[up_idx_s] == 2'b00) ? 2'b00 : cnt_q[up_idx_s] - 2'b01;
        end
      end else begin
        new_valid_s = 1'b1;
        new_tag_s   = up_tag_s;
        new_cnt_s   = actual_taken ? 2'b10 : 2'b01;
      end
    end else if (wen_BTB && !u_hit_s) begin
      // A target write implies a taken branch, so a fresh entry starts weakly taken.
      new_valid_s = 1'b1;
      new_tag_s   = up_tag_s;
      new_cnt_s   = 2'b10;
    end else begin
      new_valid_s = valid_q[up_idx_s];
    end
    if (wen_BTB) begin
      new_tgt_s = actual_target;
    end else begin
      new_tgt_s = tgt_q[up_idx_s];
    end
  end

  // Table next-state: only entry up_idx_s can change in a cycle
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    if (up_en_s) begin
      valid_d[up_idx_s] = new_valid_s;
      tag_d[up_idx_s]   = new_tag_s;
      cnt_d[up_idx_s]   = new_cnt_s;
      tgt_d[up_idx_s]   = new_tgt_s;
    end else begin
      valid_d[up_idx_s] = valid_q[up_idx_s];
    end
  end

  // Table storage, cleared asynchronously to weakly-not-taken invalid entries
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        valid_q[k] <= 1'b0;
        tag_q[k]   <= '0;
        cnt_q[k]   <= 2'b01;
        tgt_q[k]   <= 16'h0000;
      end
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
    end
  end

  // Lookup read port, optionally forwarding a colliding same-cycle update
  always_comb begin
    rd_valid_s = valid_q[lk_idx_s];
    rd_tag_s   = tag_q[lk_idx_s];
    rd_cnt_s   = cnt_q[lk_idx_s];
    rd_tgt_s   = tgt_q[lk_idx_s];
`ifdef BP_WRITE_BYPASS_EN
    if (up_en_s && (up_idx_s == lk_idx_s) && (up_tag_s == lk_tag_s)) begin
      rd_valid_s = new_valid_s;
      rd_tag_s   = new_tag_s;
      rd_cnt_s   = new_cnt_s;
      rd_tgt_s   = new_tgt_s;
    end else begin
      rd_valid_s = valid_q[lk_idx_s];
    end
`endif
  end

  assign rd_hit_s         = rd_valid_s && (rd_tag_s == lk_tag_s);
  assign hit              = rd_hit_s;
  assign prediction       = rd_hit_s ? rd_cnt_s : 2'b00;
  assign predicted_taken  = rd_hit_s && rd_cnt_s[1];
  assign predicted_target = rd_hit_s ? rd_tgt_s : 16'h0000;

endmodule

// File: tb/tb_dynamic_branch_predictor.sv
// Directed self-checking bench for dynamic_branch_predictor.
module tb_dynamic_branch_predictor;

  logic        clk;
  logic        rst;
  logic [15:0] PC_curr;
  logic [15:0] IF_ID_PC_curr;
  logic        wen_BHT;
  logic        actual_taken;
  logic        wen_BTB;
  logic [15:0] actual_target;
  logic [1:0]  prediction;
  logic        predicted_taken;
  logic [15:0] predicted_target;
  logic        hit;

  int n_vec = 0;
  int n_err = 0;

  dynamic_branch_predictor dut (
    .clk              (clk),
    .rst              (rst),
    .PC_curr          (PC_curr),
    .IF_ID_PC_curr    (IF_ID_PC_curr),
    .wen_BHT          (wen_BHT),
    .actual_taken     (actual_taken),
    .wen_BTB          (wen_BTB),
    .actual_target    (actual_target),
    .prediction       (prediction),
    .predicted_taken  (predicted_taken),
    .predicted_target (predicted_target),
    .hit              (hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    wen_BHT = 1'b0;
    wen_BTB = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_update(input logic [15:0] pc, input logic bht, input logic tk,
                           input logic btb, input logic [15:0] tgt);
    @(negedge clk);
    IF_ID_PC_curr = pc;
    wen_BHT = bht;
    actual_taken = tk;
    wen_BTB = btb;
    actual_target = tgt;
    @(posedge clk);
    #1;
    wen_BHT = 1'b0;
    wen_BTB = 1'b0;
  endtask

  task automatic lookup(input logic [15:0] pc);
    PC_curr = pc;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    lookup(16'h0010);
    n_vec++; if (hit !== 1'b0) begin n_err++; $display("FAIL reset_hit got %b exp 0", hit); end
    n_vec++; if (prediction !== 2'b00) begin n_err++; $display("FAIL reset_pred got %b exp 00", prediction); end
    n_vec++; if (predicted_taken !== 1'b0) begin n_err++; $display("FAIL reset_taken got %b exp 0", predicted_taken); end
    n_vec++; if (predicted_target !== 16'h0000) begin n_err++; $display("FAIL reset_target got %h exp 0000", predicted_target); end
  endtask

  task automatic test_allocate();
    do_update(16'h0010, 1'b1, 1'b1, 1'b1, 16'h0040);
    lookup(16'h0010);
    n_vec++; if (hit !== 1'b1) begin n_err++; $display("FAIL alloc_hit got %b exp 1", hit); end
    n_vec++; if (prediction !== 2'b10) begin n_err++; $display("FAIL alloc_pred got %b exp 10", prediction); end
    n_vec++; if (predicted_taken !== 1'b1) begin n_err++; $display("FAIL alloc_taken got %b exp 1", predicted_taken); end
    n_vec++; if (predicted_target !== 16'h0040) begin n_err++; $display("FAIL alloc_target got %h exp 0040", predicted_target); end
  endtask

  task automatic test_not_taken();
    logic [1:0] exp_c [3];
    exp_c[0] = 2'b01; exp_c[1] = 2'b00; exp_c[2] = 2'b00;
    for (int i = 0; i < 3; i++) begin
      do_update(16'h0010, 1'b1, 1'b0, 1'b0, 16'hFFFF);
      lookup(16'h0010);
      n_vec++; if (prediction !== exp_c[i]) begin n_err++; $display("FAIL nt_pred[%0d] got %b exp %b", i, prediction, exp_c[i]); end
      n_vec++; if (predicted_taken !== 1'b0) begin n_err++; $display("FAIL nt_taken[%0d] got %b exp 0", i, predicted_taken); end
      n_vec++; if (predicted_target !== 16'h0040) begin n_err++; $display("FAIL nt_target[%0d] got %h exp 0040", i, predicted_target); end
    end
  endtask

  task automatic test_taken_saturate();
    do_reset();
    do_update(16'h0010, 1'b1, 1'b1, 1'b1, 16'h0040);
    for (int i = 0; i < 3; i++) begin
      do_update(16'h0010, 1'b1, 1'b1, 1'b0, 16'h0000);
      lookup(16'h0010);
      n_vec++; if (prediction !== 2'b11) begin n_err++; $display("FAIL sat_pred[%0d] got %b exp 11", i, prediction); end
      n_vec++; if (predicted_taken !== 1'b1) begin n_err++; $display("FAIL sat_taken[%0d] got %b exp 1", i, predicted_taken); end
    end
  endtask

  task automatic test_btb_only_alloc();
    do_update(16'h0014, 1'b0, 1'b0, 1'b1, 16'h1234);
    lookup(16'h0014);
    n_vec++; if (hit !== 1'b1) begin n_err++; $display("FAIL btb_hit got %b exp 1", hit); end
    n_vec++; if (prediction !== 2'b10) begin n_err++; $display("FAIL btb_pred got %b exp 10", prediction); end
    n_vec++; if (predicted_target !== 16'h1234) begin n_err++; $display("FAIL btb_target got %h exp 1234", predicted_target); end
    // Not-taken allocate on another index keeps the reset target
    do_update(16'h0016, 1'b1, 1'b0, 1'b0, 16'h5555);
    lookup(16'h0016);
    n_vec++; if (prediction !== 2'b01) begin n_err++; $display("FAIL bht_nt_pred got %b exp 01", prediction); end
    n_vec++; if (predicted_target !== 16'h0000) begin n_err++; $display("FAIL bht_nt_target got %h exp 0000", predicted_target); end
  endtask

  task automatic test_alias();
    do_update(16'h0020, 1'b1, 1'b1, 1'b1, 16'h0080);
    lookup(16'h0010);
    n_vec++; if (hit !== 1'b0) begin n_err++; $display("FAIL alias_old_hit got %b exp 0", hit); end
    n_vec++; if (predicted_target !== 16'h0000) begin n_err++; $display("FAIL alias_old_target got %h exp 0000", predicted_target); end
    lookup(16'h0020);
    n_vec++; if (hit !== 1'b1) begin n_err++; $display("FAIL alias_new_hit got %b exp 1", hit); end
    n_vec++; if (predicted_target !== 16'h0080) begin n_err++; $display("FAIL alias_new_target got %h exp 0080", predicted_target); end
  endtask

  task automatic test_same_cycle();
    logic [15:0] exp_t;
`ifdef BP_WRITE_BYPASS_EN
    exp_t = 16'h0100;
`else
    exp_t = 16'h0040;
`endif
    do_reset();
    do_update(16'h0010, 1'b1, 1'b1, 1'b1, 16'h0040);
    @(negedge clk);
    IF_ID_PC_curr = 16'h0010;
    wen_BTB = 1'b1;
    actual_target = 16'h0100;
    lookup(16'h0010);
    n_vec++; if (predicted_target !== exp_t) begin n_err++; $display("FAIL same_cyc_target got %h exp %h", predicted_target, exp_t); end
    @(posedge clk);
    #1;
    wen_BTB = 1'b0;
    lookup(16'h0010);
    n_vec++; if (predicted_target !== 16'h0100) begin n_err++; $display("FAIL after_cyc_target got %h exp 0100", predicted_target); end
    n_vec++; if (prediction !== 2'b10) begin n_err++; $display("FAIL after_cyc_pred got %b exp 10", prediction); end
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    IF_ID_PC_curr = 16'h0012;
    wen_BHT = 1'b1;
    actual_taken = 1'b1;
    wen_BTB = 1'b1;
    actual_target = 16'h0777;
    PC_curr = 16'h0010;
    #2;
    rst = 1'b1;
    #1;
    n_vec++; if (hit !== 1'b0) begin n_err++; $display("FAIL midrst_hit got %b exp 0", hit); end
    n_vec++; if (prediction !== 2'b00) begin n_err++; $display("FAIL midrst_pred got %b exp 00", prediction); end
    n_vec++; if (predicted_taken !== 1'b0) begin n_err++; $display("FAIL midrst_taken got %b exp 0", predicted_taken); end
    n_vec++; if (predicted_target !== 16'h0000) begin n_err++; $display("FAIL midrst_target got %h exp 0000", predicted_target); end
    @(negedge clk);
    rst = 1'b0;
    wen_BHT = 1'b0;
    wen_BTB = 1'b0;
    lookup(16'h0012);
    n_vec++; if (hit !== 1'b0) begin n_err++; $display("FAIL midrst_discard_hit got %b exp 0", hit); end
  endtask

  initial begin
    rst = 1'b1;
    PC_curr = 16'h0000;
    IF_ID_PC_curr = 16'h0000;
    wen_BHT = 1'b0;
    actual_taken = 1'b0;
    wen_BTB = 1'b0;
    actual_target = 16'h0000;
    test_reset();
    test_allocate();
    test_not_taken();
    test_taken_saturate();
    test_btb_only_alloc();
    test_alias();
    test_same_cycle();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
